hall_rpm_meter: RTL

Measures motor speed from the three hall sensor lines and answers the PI controller's speed requests. On each request pulse it returns a 13-bit RPM value with a one-cycle valid strobe. It sits beside the BLDC controller: the controller's get-RPM request drives this block, and this block's RPM/valid outputs feed the controller's RPM/valid inputs. Internally it combines hall synchronisation, a transition-period counter, a stall timeout and a sequential 32-bit divider.

---
 rtl/hall_rpm_meter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/hall_rpm_meter.sv
// hall_rpm_meter: measures the hall-transition period of a BLDC motor and, on
// request, converts it to RPM with a 32-cycle restoring divider.
// RPM = (10 * CLK_FREQ_HZ / POLE_PAIRS) / period, clamped to 13 bits.
module hall_rpm_meter #(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned POLE_PAIRS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_n_reset,
    input  logic [2:0]  i_hall_state,
    input  logic        i_get_RPM,
    output logic [12:0] o_RPM,
    output logic        o_valid,
    output logic        o_busy,
    output logic [31:0] o_period,
    output logic        o_stalled,
    output logic        o_hall_fault
);

    // Dividend constant: 60 s/min * f_clk / (6 transitions * pole pairs).
    localparam logic [63:0] K_WIDE    = (64'd10 * 64'(CLK_FREQ_HZ)) / 64'(POLE_PAIRS);
    localparam logic [31:0] K_DIVIDEND = K_WIDE[31:0];
    localparam logic [31:0] TIMEOUT_C  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] RPM_MAX    = 32'd8191;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // A hall code is usable only when it is neither all-low nor all-high.
    function automatic logic code_valid(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Hall synchronisation and history
    logic [2:0]  hall_meta_q;
    logic [2:0]  hall_sync_q;
    logic        meta_vld_q;
    logic [2:0]  hall_prev_q;
    logic        fault_q;
    logic        transition_s;

    // Period measurement
    logic [31:0] cnt_q,       cnt_d;
    logic        armed_q,     armed_d;
    logic [31:0] period_q,    period_d;
    logic        period_ok_q, period_ok_d;
    logic        stalled_q,   stalled_d;

    // Request FSM and divider
    state_t      state_q,     state_d;
    logic [31:0] dvs_q,       dvs_d;
    logic [31:0] dvd_q,       dvd_d;
    logic [31:0] rem_q,       rem_d;
    logic [4:0]  bit_q,       bit_d;
    logic [12:0] rpm_q,       rpm_d;
    logic        valid_q,     valid_d;
    logic        busy_q,      busy_d;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;

    // Two-flop synchroniser; the previous-code register only follows valid codes.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            hall_meta_q <= 3'b000;
            hall_sync_q <= 3'b000;
            meta_vld_q  <= 1'b0;
            hall_prev_q <= 3'b000;
            fault_q     <= 1'b0;
        end else begin
            hall_meta_q <= i_hall_state;
            hall_sync_q <= hall_meta_q;
            meta_vld_q  <= 1'b1;
            // Fault flag lines up with the code that enters the sync stage.
            fault_q     <= meta_vld_q && !code_valid(hall_meta_q);
            if (code_valid(hall_sync_q)) begin
                hall_prev_q <= hall_sync_q;
            end else begin
                hall_prev_q <= hall_prev_q;
            end
        end
    end

    assign transition_s = code_valid(hall_sync_q) && (hall_sync_q != hall_prev_q);

    // Period counter, first/second transition tracking and stall detection.
    always_comb begin
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        period_d    = period_q;
        period_ok_d = period_ok_q;
        stalled_d   = stalled_q;

        if (transition_s) begin
            cnt_d = 32'd0;
        end else if (cnt_q < TIMEOUT_C) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (transition_s) begin
            if (armed_q) begin
                // Counter was zeroed at the previous transition edge, hence +1.
                period_d    = cnt_q + 32'd1;
                period_ok_d = 1'b1;
                stalled_d   = 1'b0;
            end else begin
                armed_d = 1'b1;
            end
        end else if (cnt_d == TIMEOUT_C) begin
            armed_d     = 1'b0;
            period_ok_d = 1'b0;
            stalled_d   = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Period measurement state registers.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            cnt_q       <= 32'd0;
            armed_q     <= 1'b0;
            period_q    <= 32'd0;
            period_ok_q <= 1'b0;
            stalled_q   <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            period_q    <= period_d;
            period_ok_q <= period_ok_d;
            stalled_q   <= stalled_d;
        end
    end

    // One restoring-division step: shift in the next dividend bit and trial-subtract.
    assign rem_shift_s = {rem_q, dvd_q[31]};
    assign diff_s      = rem_shift_s - {1'b0, dvs_q};

    // Request FSM next-state logic and divider datapath.
    always_comb begin
        state_d = state_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        rpm_d   = rpm_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_get_RPM) begin
                    if (period_ok_q) begin
                        dvs_d   = period_q;
                        dvd_d   = K_DIVIDEND;
                        rem_d   = 32'd0;
                        bit_d   = 5'd0;
                        state_d = ST_DIVIDE;
                    end else begin
                        dvd_d   = 32'd0;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                // Quotient bits are shifted into the dividend register.
                if (diff_s[32]) begin
                    rem_d = rem_shift_s[31:0];
                    dvd_d = {dvd_q[30:0], 1'b0};
                end else begin
                    rem_d = diff_s[31:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd31) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_DONE: begin
                if (dvd_q > RPM_MAX) begin
                    rpm_d = 13'h1FFF;
                end else begin
                    rpm_d = dvd_q[12:0];
                end
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy stays up through the valid cycle so no request is taken before it ends.
        busy_d = (state_d != ST_IDLE) || valid_d;
    end

    // Request FSM, divider and result registers.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q <= ST_IDLE;
            dvs_q   <= 32'd0;
            dvd_q   <= 32'd0;
            rem_q   <= 32'd0;
            bit_q   <= 5'd0;
            rpm_q   <= 13'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            rpm_q   <= rpm_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_RPM        = rpm_q;
    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_period     = period_q;
    assign o_stalled    = stalled_q;
    assign o_hall_fault = fault_q;

endmodule
